retire_queue: RTL and testbench
===============================

# retire_queue

In-order retirement buffer that sits directly upstream of the commit stage. It allocates one slot per issued instruction and captures results and exceptions from the functional-unit writeback ports. It presents the two oldest entries to the commit stage, which retires them with `commit_ack_i`. It is a slim scoreboard: there is no operand forwarding and no register-renaming lookup.

## Interface

Parameters:
- NR_ENTRIES, 8: queue depth; must be a power of two and at least 4.
- NR_WB_PORTS, 2: number of writeback ports.
- NR_COMMIT_PORTS, 2: number of commit ports; fixed at 2, and the commit stage depends on this.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous, active-low reset.
- flush_i  in  1  invalidates all entries; pointers return to 0.
- issue_valid_i  in  1  an issue request is present.
- issue_instr_i  in  scoreboard_entry_t  the instruction to allocate. A set `.valid` means it is already finished, e.g. it carries a decode exception.
- issue_ready_o  out  1  a free slot exists.
- issue_trans_id_o  out  TRANS_ID_BITS  slot index that the current issue will receive.
- wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe.
- wb_trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  target slot.
- wb_data_i  in  NR_WB_PORTS x 64  result.
- wb_ex_i  in  NR_WB_PORTS x exception_t  exception raised by the functional unit.
- commit_instr_o  out  NR_COMMIT_PORTS x scoreboard_entry_t  oldest and second-oldest entries.
- commit_ack_i  in  NR_COMMIT_PORTS  retire strobe from the commit stage.
- count_o  out  TRANS_ID_BITS+1  number of occupied slots.
- empty_o  out  1  count_o == 0.

## Operation

- State:
  - `mem[NR_ENTRIES]` of scoreboard_entry_t.
  - `issued[NR_ENTRIES]` flag per slot.
  - Pointers `head` (oldest) and `tail` (next free), each TRANS_ID_BITS wide and wrapping modulo NR_ENTRIES.
  - `count`, TRANS_ID_BITS+1 wide.
- Issue:
  - Fires when issue_valid_i && issue_ready_o.
  - Writes issue_instr_i into mem[tail] and sets issued[tail]. tail advances by 1.
  - issue_trans_id_o = tail. issue_ready_o = (count != NR_ENTRIES).
- Writeback, per port p:
  - Applies when wb_valid_i[p] is high and the target slot is issued.
  - Sets mem[id].result = wb_data_i[p] and mem[id].valid = 1.
  - If wb_ex_i[p].valid, also sets mem[id].ex = wb_ex_i[p].
  - Writeback to a non-issued slot is ignored.
  - If two ports target the same slot (illegal), the lower port index wins.
- Commit view:
  - commit_instr_o[0] = mem[head]. Its .valid = issued[head] && mem[head].valid.
  - commit_instr_o[1] = mem[head+1]. Its .valid = (count >= 2) && issued[head+1] && mem[head+1].valid.
- Retire:
  - Number popped = commit_ack_i[0] + commit_ack_i[1].
  - Popped slots clear `issued` and `.valid`. head advances by the number popped.
  - commit_ack_i[1] without commit_ack_i[0] is illegal; flag it with an assertion.
  - An ack on an entry whose output .valid is low is illegal; flag it with an assertion.
- count update: count_next = count + issue_fire − popped. Issue and retire may occur in the same cycle.
- Priority: flush_i beats everything else in the same cycle.
  - Flush clears all `issued` flags and sets head = tail = count = 0.
  - Issue, writeback and ack in that cycle are dropped.

## Timing

- Reset values, after rst_ni is sampled low at a clock edge: issue_ready_o=1, issue_trans_id_o=0, commit_instr_o[*].valid=0, count_o=0, empty_o=1. mem contents are don't-care.
- Reset asserted mid-operation has the same effect as flush, at the next edge.
- Issue to commit visibility: one cycle, when issue_instr_i.valid=1.
- Writeback to commit visibility: one cycle. There is no combinational bypass from wb_* to commit_instr_o.
- Full boundary: issue_ready_o is computed from the registered count only, so a same-cycle retire does not enable issue while full. Issue resumes the next cycle.
- Empty boundary: a slot issued and acked in the same cycle is impossible, because visibility is registered.
- Pointer wrap: head+1 and tail wrap at NR_ENTRIES−1 → 0 with no bubble.
- commit_instr_o is a pure function of registered state. commit_ack_i may therefore depend combinationally on commit_instr_o, as the commit stage requires.

## Structure

- scoreboard_entry_t and exception_t are taken from ariane_pkg.
- Add `TRANS_ID_BITS = $clog2(NR_ENTRIES)` to ariane_pkg, because it is shared with the functional units.
- Implement as a single flat module; no sub-module is needed.
- Assertions belong in a `pragma translate_off` region inside the module.

## Test plan

- Reset, then issue 3 instructions with .valid=0 → trans_ids 0,1,2; count_o=3; commit_instr_o[0].valid=0 until wb on id 0, then valid on the next cycle with result = wb data.
- Writeback ids 1 and 0 in the same cycle on ports 0 and 1; ack both → both ports valid one cycle later; head moves 0→2; count_o drops by 2.
- Fill to 8 entries → issue_ready_o=0. Ack 1 while issue_valid_i is held → no issue that cycle; ready=1 the next cycle; new trans_id=0 (wrap).
- Writeback with wb_ex_i.valid=1, cause=5 → commit_instr_o[0].ex.cause=5 and ex.valid=1.
- flush_i together with issue and wb in the same cycle → count_o=0, empty_o=1, all commit valids 0, issue_trans_id_o=0.
- Issue with issue_instr_i.valid=1 into an empty queue → commit_instr_o[0].valid=1 on the next cycle with no writeback.

Source files
------------

// File: rtl/retire_queue_pkg.sv
// Shared types and sizing for the retire queue and the functional units that write back into it.
package retire_queue_pkg;

   localparam int unsigned RQ_NR_ENTRIES      = 8;
   localparam int unsigned RQ_NR_WB_PORTS     = 2;
   localparam int unsigned RQ_NR_COMMIT_PORTS = 2;
   localparam int unsigned TRANS_ID_BITS      = $clog2(RQ_NR_ENTRIES);

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [63:0]              pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [7:0]               op;
      logic [4:0]               rd;
      logic [63:0]              result;
      logic                     valid;
      exception_t               ex;
   } scoreboard_entry_t;

endpackage

// File: rtl/retire_queue_if.sv
// Issue, writeback and commit signalling between the pipeline and the retire queue.
interface retire_queue_if
   import retire_queue_pkg::*;
#(
   parameter int unsigned NR_WB_PORTS     = RQ_NR_WB_PORTS,
   parameter int unsigned NR_COMMIT_PORTS = RQ_NR_COMMIT_PORTS
);

   logic                                        issue_valid_i;
   scoreboard_entry_t                           issue_instr_i;
   logic                                        issue_ready_o;
   logic [TRANS_ID_BITS-1:0]                    issue_trans_id_o;
   logic [NR_WB_PORTS-1:0]                      wb_valid_i;
   logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i;
   logic [NR_WB_PORTS-1:0][63:0]                wb_data_i;
   exception_t [NR_WB_PORTS-1:0]                wb_ex_i;
   scoreboard_entry_t [NR_COMMIT_PORTS-1:0]     commit_instr_o;
   logic [NR_COMMIT_PORTS-1:0]                  commit_ack_i;
   logic [TRANS_ID_BITS:0]                      count_o;
   logic                                        empty_o;

   modport slave (
      input  issue_valid_i, issue_instr_i, wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
             commit_ack_i,
      output issue_ready_o, issue_trans_id_o, commit_instr_o, count_o, empty_o
   );

   modport master (
      output issue_valid_i, issue_instr_i, wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
             commit_ack_i,
      input  issue_ready_o, issue_trans_id_o, commit_instr_o, count_o, empty_o
   );

endinterface

// File: rtl/retire_queue.sv
// In-order retirement buffer: allocates on issue, captures writebacks, exposes the two oldest
// entries to commit. NR_ENTRIES must match the package so TRANS_ID_BITS stays consistent.
module retire_queue
   import retire_queue_pkg::*;
#(
   parameter int unsigned NR_ENTRIES      = RQ_NR_ENTRIES,
   parameter int unsigned NR_WB_PORTS     = RQ_NR_WB_PORTS,
   parameter int unsigned NR_COMMIT_PORTS = RQ_NR_COMMIT_PORTS
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   retire_queue_if.slave bus
);

   localparam int unsigned IW = TRANS_ID_BITS;
   localparam int unsigned CW = TRANS_ID_BITS + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(NR_ENTRIES);

   scoreboard_entry_t     mem_q [NR_ENTRIES];
   scoreboard_entry_t     mem_d [NR_ENTRIES];
   logic [NR_ENTRIES-1:0] issued_q, issued_d;
   logic [IW-1:0]         head_q, head_d, tail_q, tail_d, head_nxt, slot;
   logic [CW-1:0]         count_q, count_d, popped;
   logic                  issue_fire;

   assign head_nxt             = head_q + IW'(1);
   assign bus.issue_ready_o    = (count_q != FULL_COUNT);
   assign bus.issue_trans_id_o = tail_q;
   assign bus.count_o          = count_q;
   assign bus.empty_o          = (count_q == '0);
   assign issue_fire           = bus.issue_valid_i && bus.issue_ready_o;

   // Commit view reads registered state only, so the ack may depend on it combinationally.
   always_comb begin
      bus.commit_instr_o[0]       = mem_q[head_q];
      bus.commit_instr_o[0].valid = issued_q[head_q] && mem_q[head_q].valid;
      bus.commit_instr_o[1]       = mem_q[head_nxt];
      bus.commit_instr_o[1].valid = (count_q >= CW'(2)) && issued_q[head_nxt]
                                    && mem_q[head_nxt].valid;
   end

   always_comb begin
      mem_d    = mem_q;
      issued_d = issued_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      popped   = '0;
      slot     = '0;
      if (flush_i) begin
         issued_d = '0;
         head_d   = '0;
         tail_d   = '0;
         count_d  = '0;
      end else begin
         if (issue_fire) begin
            mem_d[tail_q]    = bus.issue_instr_i;
            issued_d[tail_q] = 1'b1;
         end
         // Walk ports high to low so the lowest port wins a same-slot collision.
         for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
            if (bus.wb_valid_i[p] && issued_q[bus.wb_trans_id_i[p]]) begin
               mem_d[bus.wb_trans_id_i[p]].result = bus.wb_data_i[p];
               mem_d[bus.wb_trans_id_i[p]].valid  = 1'b1;
               if (bus.wb_ex_i[p].valid) begin
                  mem_d[bus.wb_trans_id_i[p]].ex = bus.wb_ex_i[p];
               end
            end
         end
         for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (bus.commit_ack_i[i]) begin
               slot              = head_q + IW'(i);
               issued_d[slot]    = 1'b0;
               mem_d[slot].valid = 1'b0;
               popped            = popped + CW'(1);
            end
         end
         head_d  = head_q + popped[IW-1:0];
         tail_d  = tail_q + IW'(issue_fire);
         count_d = count_q + CW'(issue_fire) - popped;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         issued_q <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
      end else begin
         issued_q <= issued_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
      end
   end

   // Payload needs no reset: every read is qualified by issued_q.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   a_ack_in_order: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      bus.commit_ack_i[1] |-> bus.commit_ack_i[0]);
   a_ack0_valid: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      bus.commit_ack_i[0] |-> bus.commit_instr_o[0].valid);
   a_ack1_valid: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      bus.commit_ack_i[1] |-> bus.commit_instr_o[1].valid);

endmodule

// File: tb/tb_retire_queue.sv
// Directed bench for retire_queue: a queue-based reference model checked every cycle, plus
// hand-computed literal expectations at the interesting points.
module tb_retire_queue;
   import retire_queue_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   retire_queue_if bus ();

   retire_queue dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .flush_i(flush),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Reference model: program-ordered list of live slot ids plus per-slot payload.
   int                q [$];
   int                m_tail;
   scoreboard_entry_t m_mem [8];
   bit                m_iss [8];
   bit                wb_done [8];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic scoreboard_entry_t mk(input logic [63:0] pc, input logic v);
      scoreboard_entry_t e;
      e       = '0;
      e.pc    = pc;
      e.op    = pc[7:0];
      e.rd    = pc[4:0];
      e.valid = v;
      return e;
   endfunction

   always @(posedge clk) begin
      int id;
      int npop;
      if (!rst_n || flush) begin
         q.delete();
         m_tail = 0;
         for (int s = 0; s < 8; s++) m_iss[s] = 1'b0;
      end else begin
         bit fire;
         fire = bus.issue_valid_i && (q.size() != 8);
         for (int s = 0; s < 8; s++) wb_done[s] = 1'b0;
         for (int p = 0; p < 2; p++) begin
            id = int'(bus.wb_trans_id_i[p]);
            if (bus.wb_valid_i[p] && m_iss[id] && !wb_done[id]) begin
               wb_done[id]         = 1'b1;
               m_mem[id].result    = bus.wb_data_i[p];
               m_mem[id].valid     = 1'b1;
               if (bus.wb_ex_i[p].valid) m_mem[id].ex = bus.wb_ex_i[p];
            end
         end
         npop = int'(bus.commit_ack_i[0]) + int'(bus.commit_ack_i[1]);
         for (int k = 0; k < npop; k++) begin
            id        = q.pop_front();
            m_iss[id] = 1'b0;
         end
         if (fire) begin
            m_mem[m_tail] = bus.issue_instr_i;
            m_iss[m_tail] = 1'b1;
            q.push_back(m_tail);
            m_tail = (m_tail + 1) % 8;
         end
      end
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      int n;
      bit e0v, e1v;
      if (chk_en) begin
         n   = q.size();
         e0v = (n >= 1) ? m_mem[q[0]].valid : 1'b0;
         e1v = (n >= 2) ? m_mem[q[1]].valid : 1'b0;
         check("ready", bus.issue_ready_o, n != 8);
         check("trans_id", bus.issue_trans_id_o, m_tail);
         check("count", bus.count_o, n);
         check("empty", bus.empty_o, n == 0);
         check("c0_valid", bus.commit_instr_o[0].valid, e0v);
         check("c1_valid", bus.commit_instr_o[1].valid, e1v);
         if (e0v) check("c0_entry", bus.commit_instr_o[0], m_mem[q[0]]);
         if (e1v) check("c1_entry", bus.commit_instr_o[1], m_mem[q[1]]);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      flush             = 1'b0;
      bus.issue_valid_i = 1'b0;
      bus.issue_instr_i = '0;
      bus.wb_valid_i    = '0;
      bus.wb_trans_id_i = '0;
      bus.wb_data_i     = '0;
      bus.wb_ex_i       = '0;
      bus.commit_ack_i  = '0;
   endtask

   task automatic issue(input logic [63:0] pc, input logic v);
      bus.issue_valid_i = 1'b1;
      bus.issue_instr_i = mk(pc, v);
   endtask

   task automatic wb(input int p, input logic [2:0] id, input logic [63:0] data);
      bus.wb_valid_i[p]    = 1'b1;
      bus.wb_trans_id_i[p] = id;
      bus.wb_data_i[p]     = data;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) step();
      check("rst_ready", bus.issue_ready_o, 1);
      check("rst_trans_id", bus.issue_trans_id_o, 0);
      check("rst_count", bus.count_o, 0);
      check("rst_empty", bus.empty_o, 1);
      check("rst_c0_valid", bus.commit_instr_o[0].valid, 0);
      check("rst_c1_valid", bus.commit_instr_o[1].valid, 0);
      rst_n = 1'b1;

      // Three unfinished instructions, then a writeback makes the oldest visible.
      for (int i = 0; i < 3; i++) begin
         check("lit_issue_id", bus.issue_trans_id_o, i);
         issue(64'h10 + 64'(i), 1'b0);
         step();
      end
      idle();
      check("lit_count3", bus.count_o, 3);
      check("lit_c0_pending", bus.commit_instr_o[0].valid, 0);
      wb(0, 3'd0, 64'hAAAA);
      step();
      idle();
      check("lit_wb_valid", bus.commit_instr_o[0].valid, 1);
      check("lit_wb_result", bus.commit_instr_o[0].result, 64'hAAAA);

      // Two ports in one cycle, then a double retire.
      wb(0, 3'd1, 64'h1111);
      wb(1, 3'd0, 64'h2222);
      step();
      idle();
      check("lit_dual_c0", bus.commit_instr_o[0].result, 64'h2222);
      check("lit_dual_c1", bus.commit_instr_o[1].result, 64'h1111);
      check("lit_dual_c1_valid", bus.commit_instr_o[1].valid, 1);
      bus.commit_ack_i = 2'b11;
      step();
      idle();
      check("lit_pop2_count", bus.count_o, 1);
      check("lit_pop2_head", bus.commit_instr_o[0].pc, 64'h12);

      // Same-slot collision with an exception on the winning port.
      wb(0, 3'd2, 64'h3333);
      bus.wb_ex_i[0].valid = 1'b1;
      bus.wb_ex_i[0].cause = 64'd5;
      wb(1, 3'd2, 64'h4444);
      step();
      idle();
      check("lit_collide_result", bus.commit_instr_o[0].result, 64'h3333);
      check("lit_ex_cause", bus.commit_instr_o[0].ex.cause, 5);
      check("lit_ex_valid", bus.commit_instr_o[0].ex.valid, 1);
      bus.commit_ack_i = 2'b01;
      step();
      idle();
      check("lit_drain_empty", bus.empty_o, 1);

      // Flush beats a same-cycle issue and writeback.
      issue(64'h20, 1'b0);
      step();
      issue(64'h21, 1'b0);
      step();
      issue(64'h22, 1'b0);
      wb(0, 3'd3, 64'h5555);
      flush = 1'b1;
      step();
      idle();
      check("lit_flush_count", bus.count_o, 0);
      check("lit_flush_empty", bus.empty_o, 1);
      check("lit_flush_c0", bus.commit_instr_o[0].valid, 0);
      check("lit_flush_c1", bus.commit_instr_o[1].valid, 0);
      check("lit_flush_id", bus.issue_trans_id_o, 0);

      // Already-finished instruction is committable one cycle after issue.
      issue(64'h30, 1'b1);
      step();
      idle();
      check("lit_done_valid", bus.commit_instr_o[0].valid, 1);
      check("lit_done_pc", bus.commit_instr_o[0].pc, 64'h30);

      // Fill to full; a same-cycle retire must not let the held issue through.
      for (int i = 0; i < 7; i++) begin
         issue(64'h40 + 64'(i), 1'b1);
         step();
      end
      issue(64'h50, 1'b1);
      check("lit_full_ready", bus.issue_ready_o, 0);
      check("lit_full_count", bus.count_o, 8);
      bus.commit_ack_i = 2'b01;
      step();
      bus.commit_ack_i = 2'b00;
      check("lit_full_ack_count", bus.count_o, 7);
      check("lit_full_ack_ready", bus.issue_ready_o, 1);
      check("lit_wrap_id", bus.issue_trans_id_o, 0);
      step();
      idle();
      check("lit_refill_count", bus.count_o, 8);
      check("lit_refill_id", bus.issue_trans_id_o, 1);

      // Drain in pairs; the last pair straddles slot 7 -> 0.
      for (int d = 0; d < 4; d++) begin
         if (d == 3) begin
            check("lit_wrap_c0", bus.commit_instr_o[0].pc, 64'h46);
            check("lit_wrap_c1", bus.commit_instr_o[1].pc, 64'h50);
         end
         bus.commit_ack_i = 2'b11;
         step();
      end
      idle();
      check("lit_wrap_empty", bus.empty_o, 1);

      // Reset mid-operation behaves like a flush.
      issue(64'h60, 1'b1);
      step();
      issue(64'h61, 1'b0);
      step();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("lit_midrst_count", bus.count_o, 0);
      check("lit_midrst_empty", bus.empty_o, 1);
      check("lit_midrst_id", bus.issue_trans_id_o, 0);
      check("lit_midrst_c0", bus.commit_instr_o[0].valid, 0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
